// File: rtl/clock_scale_detect.sv
// Recovers the scale factor (half-period minus one, in clk cycles) of a divided clock on sig_in.
// Latency: valid rises SYNC_STAGES clk edges after the edge that first samples a new sig_in level.
// Backpressure: none; valid is a single-cycle strobe and the consumer must take it when it fires.
module clock_scale_detect #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_in,
    input  logic        enable,
    output logic [10:0] scale_out,
    output logic        valid,
    output logic        locked,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [10:0] CNT_MAX = 11'd2047;
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_COUNT);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_lvl;
    logic                   w_edge;
    logic [10:0]            r_cnt;
    logic [10:0]            w_cnt_nxt;
    logic [3:0]             r_match;
    logic [3:0]             w_match_nxt;
    logic [10:0]            r_scale;
    logic [10:0]            w_scale_nxt;
    logic                   r_valid;
    logic                   w_valid_nxt;
    logic                   r_locked;
    logic                   w_locked_nxt;
    logic                   r_timeout;
    logic                   w_timeout_nxt;

    // Both polarities of the synchronized input count as a measurement edge.
    assign w_lvl  = r_sync[SYNC_STAGES-1];
    assign w_edge = w_lvl ^ r_prev;

    assign scale_out = r_scale;
    assign valid     = r_valid;
    assign locked    = r_locked;
    assign timeout   = r_timeout;

    // Synchronizer chain and previous-level flop; keeps running even while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= w_lvl;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_match   <= '0;
            r_scale   <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_match   <= w_match_nxt;
            r_scale   <= w_scale_nxt;
            r_valid   <= w_valid_nxt;
            r_locked  <= w_locked_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state logic: measure edge spacing, track repeated values, detect a stalled input.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_match_nxt   = r_match;
        w_scale_nxt   = r_scale;
        w_valid_nxt   = 1'b0;
        w_locked_nxt  = r_locked;
        w_timeout_nxt = r_timeout;

        if (!enable) begin
            // scale_out is deliberately kept so the last result stays readable.
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_match_nxt   = '0;
            w_locked_nxt  = 1'b0;
            w_timeout_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // The edge leaving idle only starts the count; its spacing is unknown.
                    w_cnt_nxt   = '0;
                    w_match_nxt = '0;
                    if (w_edge) begin
                        w_state_nxt   = ST_MEASURE;
                        w_timeout_nxt = 1'b0;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (w_edge) begin
                        // An edge on the final count still wins over the timeout.
                        w_cnt_nxt   = '0;
                        w_valid_nxt = 1'b1;
                        w_scale_nxt = r_cnt;
                        if (r_match == 4'd0) begin
                            w_match_nxt = 4'd1;
                        end else if (r_cnt == r_scale) begin
                            w_match_nxt = (r_match >= LOCK_N) ? LOCK_N : 4'(r_match + 4'd1);
                        end else begin
                            w_match_nxt = 4'd1;
                        end
                        if (w_match_nxt == LOCK_N) begin
                            w_state_nxt  = ST_LOCKED;
                            w_locked_nxt = 1'b1;
                        end else begin
                            w_state_nxt  = ST_MEASURE;
                            w_locked_nxt = 1'b0;
                        end
                    end else if (r_cnt == CNT_MAX) begin
                        w_state_nxt   = ST_IDLE;
                        w_cnt_nxt     = '0;
                        w_match_nxt   = '0;
                        w_locked_nxt  = 1'b0;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = 11'(r_cnt + 11'd1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_match_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_scale_detect.sv
// Bench for clock_scale_detect: timestamp-based reference model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_clock_scale_detect;

    localparam int SYNC = 2;
    localparam int LOCK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_in;
    logic        enable;
    logic [10:0] scale_out;
    logic        valid;
    logic        locked;
    logic        timeout;

    always #5 clk = ~clk;

    clock_scale_detect #(
        .SYNC_STAGES(SYNC),
        .LOCK_COUNT (LOCK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .enable   (enable),
        .scale_out(scale_out),
        .valid    (valid),
        .locked   (locked),
        .timeout  (timeout)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_tog_cyc   = 0;
    int last_valid_cyc = -1;
    int to_rise_cyc    = -1;
    logic prev_to = 1'b0;

    typedef struct {
        int scale;
        int lk;
        int to;
        int cyc;
    } strobe_t;
    strobe_t strobes[$];

    // Reference model: edges are input level changes delayed by the synchronizer,
    // a measurement is the cycle distance between consecutive edges minus one.
    bit hist[$];
    bit m_run;
    int m_last;
    int meas[$];
    int e_scale;
    bit e_valid;
    bit e_locked;
    bit e_timeout;
    bit m_ev;
    int m_el;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit last_all_equal();
        if (meas.size() < LOCK) return 1'b0;
        foreach (meas[i]) if (meas[i] != meas[0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int sc(input int i);
        return (strobes.size() > i) ? strobes[i].scale : -1;
    endfunction

    function automatic int lk(input int i);
        return (strobes.size() > i) ? strobes[i].lk : -1;
    endfunction

    function automatic int to_at(input int i);
        return (strobes.size() > i) ? strobes[i].to : -1;
    endfunction

    function automatic int cy(input int i);
        return (strobes.size() > i) ? strobes[i].cyc : -1;
    endfunction

    // Model update on each rising edge, then compare and log just after it.
    always begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < SYNC + 2; i++) hist.push_back(1'b0);
            m_run     = 1'b0;
            meas.delete();
            e_scale   = 0;
            e_valid   = 1'b0;
            e_locked  = 1'b0;
            e_timeout = 1'b0;
        end else begin
            hist.push_back(sig_in);
            void'(hist.pop_front());
            m_ev    = hist[hist.size() - 1 - SYNC] != hist[hist.size() - 2 - SYNC];
            e_valid = 1'b0;
            if (!enable) begin
                m_run     = 1'b0;
                meas.delete();
                e_locked  = 1'b0;
                e_timeout = 1'b0;
            end else if (!m_run) begin
                if (m_ev) begin
                    m_run     = 1'b1;
                    m_last    = cyc;
                    e_timeout = 1'b0;
                    meas.delete();
                end
            end else begin
                m_el = cyc - m_last - 1;
                if (m_ev) begin
                    e_scale = m_el;
                    e_valid = 1'b1;
                    m_last  = cyc;
                    meas.push_back(m_el);
                    if (meas.size() > LOCK) void'(meas.pop_front());
                    e_locked = last_all_equal();
                end else if (m_el == 2047) begin
                    e_timeout = 1'b1;
                    e_locked  = 1'b0;
                    m_run     = 1'b0;
                    meas.delete();
                end
            end
        end
        #1;
        tests++;
        if (valid !== e_valid || locked !== e_locked || timeout !== e_timeout ||
            scale_out !== 11'(e_scale)) begin
            fails++;
            $display("FAIL model cycle %0d: dut valid=%b locked=%b timeout=%b scale=%0d, model valid=%b locked=%b timeout=%b scale=%0d",
                     cyc, valid, locked, timeout, scale_out, e_valid, e_locked, e_timeout, e_scale);
        end
        if (valid === 1'b1) begin
            strobes.push_back('{int'(scale_out), int'(locked), int'(timeout), cyc});
            last_valid_cyc = cyc;
        end
        if (timeout === 1'b1 && prev_to === 1'b0) to_rise_cyc = cyc;
        prev_to = timeout;
    end

    // Toggle sig_in n times, one toggle every 'period' cycles, leaving 'period' cycles after the last.
    task automatic toggle(input int period, input int n);
        repeat (n) begin
            sig_in = ~sig_in;
            last_tog_cyc = cyc;
            repeat (period) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        enable = 1'b0;
        idle(3);
        check("reset scale", int'(scale_out), 0);
        check("reset valid", int'(valid), 0);
        check("reset locked", int'(locked), 0);
        check("reset timeout", int'(timeout), 0);

        // S=5: lock on the 4th strobe; valid SYNC+1 cycles after the toggle's falling edge.
        rst    = 1'b0;
        enable = 1'b1;
        strobes.delete();
        toggle(6, 8);
        check("s5 strobe count", strobes.size(), 7);
        check("s5 first scale", sc(0), 5);
        check("s5 unlocked at 3rd", lk(2), 0);
        check("s5 locked at 4th", lk(3), 1);
        check("s5 latency", cy(6) - last_tog_cyc, SYNC + 1);

        // Switch to toggling every 10: first 9 drops lock, 4th 9 relocks.
        strobes.delete();
        toggle(10, 5);
        check("s9 leftover scale", sc(0), 5);
        check("s9 leftover locked", lk(0), 1);
        check("s9 first scale", sc(1), 9);
        check("s9 first unlocked", lk(1), 0);
        check("s9 3rd unlocked", lk(3), 0);
        check("s9 4th locked", lk(4), 1);

        // S=0, then stop toggling while locked.
        strobes.delete();
        toggle(1, 8);
        for (int i = 0; i < 2300; i++) begin
            if (timeout === 1'b1) break;
            @(negedge clk);
        end
        check("s0 strobe count", strobes.size(), 8);
        check("s0 scale", sc(7), 0);
        check("s0 3rd unlocked", lk(3), 0);
        check("s0 4th locked", lk(4), 1);
        check("timeout raised", int'(timeout), 1);
        check("timeout distance", to_rise_cyc - last_valid_cyc, 2048);
        check("timeout unlocks", int'(locked), 0);
        idle(5);
        check("no valid after timeout", strobes.size(), 8);

        // Resume at S=5: timeout clears on the first edge, value on the second.
        strobes.delete();
        toggle(6, 2);
        check("resume strobe count", strobes.size(), 1);
        check("resume scale", sc(0), 5);
        check("resume timeout clear", to_at(0), 0);

        // S=2047: edge on the final count wins, no timeout.
        strobes.delete();
        toggle(2048, 5);
        check("s2047 scale", sc(4), 2047);
        check("s2047 3rd unlocked", lk(3), 0);
        check("s2047 4th locked", lk(4), 1);
        check("s2047 no timeout", int'(timeout), 0);

        // Reset mid-period while locked on S=5.
        toggle(6, 6);
        check("pre-reset locked", int'(locked), 1);
        idle(2);
        rst = 1'b1;
        #1;
        check("async reset scale", int'(scale_out), 0);
        check("async reset locked", int'(locked), 0);
        check("async reset valid", int'(valid), 0);
        idle(2);
        rst = 1'b0;
        strobes.delete();
        toggle(6, 3);
        check("post-reset strobe count", strobes.size(), 2);
        check("post-reset scale", sc(0), 5);

        // Disable for 10 cycles while locked, then relock.
        toggle(6, 3);
        check("pre-disable locked", int'(locked), 1);
        enable = 1'b0;
        idle(10);
        check("disable unlocks", int'(locked), 0);
        check("disable timeout", int'(timeout), 0);
        check("disable holds scale", int'(scale_out), 5);
        enable = 1'b1;
        strobes.delete();
        toggle(6, 5);
        check("relock strobe count", strobes.size(), 4);
        check("relock 3rd unlocked", lk(2), 0);
        check("relock 4th locked", lk(3), 1);
        check("relock scale", sc(3), 5);

        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_scale_detect.md
CLOCK_SCALE_DETECT -- requirements
Module: clock_scale_detect

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of input synchronizer flops (legal range 2..4).
REQ-002 Parameter: LOCK_COUNT, default 4, number of consecutive identical measurements required for lock (legal range 2..15).
REQ-003 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: sig_in  input  1  divided clock to be measured; asynchronous to clk.
REQ-006 Port: enable  input  1  measurement enable; low forces idle.
REQ-007 Port: scale_out  output  11  recovered scale factor, i.e. half-period in clk cycles minus 1.
REQ-008 Port: valid  output  1  one-cycle strobe; scale_out updated this cycle.
REQ-009 Port: locked  output  1  LOCK_COUNT consecutive equal measurements seen.
REQ-010 Port: timeout  output  1  sticky flag: no sig_in edge within 2048 cycles.

Function
REQ-011 sig_in SHALL pass through SYNC_STAGES flops; edge = synchronized level differs from its registered previous value (both polarities count).
REQ-012 Internal 11-bit counter cnt SHALL clear to 0 on every edge cycle and increment by 1 on every other cycle while in MEASURE or LOCKED.
REQ-013 States: IDLE, MEASURE, LOCKED; 2-bit encoding free.
REQ-014 IDLE: cnt held at 0, match count 0; on edge with enable=1 -> MEASURE, cnt cleared; no valid.
REQ-015 MEASURE/LOCKED, edge: scale_out <= cnt, valid <= 1 for exactly one cycle.
REQ-016 Match tracking: match count 0 -> 1; cnt == current scale_out -> match count +1 (saturate at LOCK_COUNT); cnt != scale_out -> match count = 1.
REQ-017 On reaching match count LOCK_COUNT -> LOCKED, locked <= 1 registered with the same valid strobe.
REQ-018 LOCKED, mismatching measurement: locked <= 0 with the same valid strobe, -> MEASURE.
REQ-019 Timeout: MEASURE/LOCKED, cnt == 2047 and no edge -> timeout <= 1, locked <= 0, -> IDLE, match count 0; scale_out held.
REQ-020 Edge and cnt == 2047 same cycle: edge wins; scale_out = 2047 valid, no timeout.
REQ-021 timeout clears on the next edge processed in IDLE (with enable=1) or when enable=0.
REQ-022 enable=0: -> IDLE next edge of clk, cnt 0, match 0, valid 0, locked 0, timeout 0; scale_out held; synchronizer keeps running.
REQ-023 Latency: valid SHALL rise SYNC_STAGES clk rising edges after the edge that first samples a new sig_in level.
REQ-024 First measurement after IDLE always requires two edges; the edge leaving IDLE produces no output (covers spurious edge when sig_in is high out of reset).
REQ-025 Measurement semantics: sig_in from a divider toggling every S+1 cycles (0 <= S <= 2047) SHALL yield scale_out = S.

Reset
REQ-026 rst high SHALL asynchronously force: state IDLE, synchronizer and previous-level flops 0, cnt 0, match count 0, scale_out 0, valid 0, locked 0, timeout 0.
REQ-027 Reset release SHALL be the only exit; first edge after release handled per REQ-014/REQ-024.
REQ-028 Reset asserted mid-measurement SHALL discard the partial count; no valid during or in the cycle after reset.

Verification
REQ-029 sig_in toggling every 6 clk, enable=1 -> valid per edge with scale_out=5; locked=1 on the 4th valid strobe; timeout=0 throughout.
REQ-030 Locked on S=5, switch to toggle every 10 clk -> first differing strobe scale_out=9 with locked=0; locked=1 again on the 4th strobe of value 9.
REQ-031 Toggle every clk (S=0) -> scale_out=0, locked after 4 strobes; toggle every 2048 clk -> scale_out=2047, timeout stays 0.
REQ-032 Stop toggling while locked -> exactly 2048 cycles after last edge timeout=1, locked=0, no further valid; resume toggling every 6 clk -> timeout clears at first edge, scale_out=5 on second edge.
REQ-033 rst pulsed mid-period with S=5 running -> all outputs 0 immediately; first valid only after two post-reset edges, scale_out=5.
REQ-034 enable dropped for 10 cycles while locked -> locked=0, timeout=0, scale_out held at 5; relock after re-enable with 4 further strobes.
